// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Convert a requester index into its one-hot grant vector.
  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] vec;
    vec = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    return vec;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Rotating-priority picker: first asserted request starting at ptr, wrapping mod 4.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*NREQ-1:0] req2_s;
  logic [NREQ-1:0]   rot_s;
  logic [SEL_W-1:0]  off_s;

  // Rotate the request vector so bit 0 is the current highest-priority slot.
  assign req2_s = {req, req};
  assign rot_s  = NREQ'(req2_s >> ptr);

  // Fixed-priority search on the rotated vector, then undo the rotation.
  always_comb begin
    found = 1'b1;
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: begin
        found = 1'b0;
        off_s = 2'd0;
      end
    endcase
    idx = ptr + off_s;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a shared 4:1 datapath mux.
// A grant lasts until the owner drops its request or MAX_HOLD beats have
// been accepted; priority then moves to the index after the old owner.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             out_ready,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             busy
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;

  logic             pick_found_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic             in_grant_s;
  logic             valid_s;
  logic             beat_s;
  logic             last_beat_s;
  logic             release_s;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Beat and release qualifiers derived from registered grant state.
  always_comb begin
    in_grant_s  = (state_q == ST_GRANT);
    valid_s     = in_grant_s && req[owner_q];
    beat_s      = valid_s && out_ready;
    last_beat_s = beat_s && (cnt_q == CNT_W'(MAX_HOLD - 1));
    release_s   = in_grant_s && (!req[owner_q] || last_beat_s);
  end

  // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_GRANT;
          owner_d = pick_idx_s;
          gnt_d   = idx_to_onehot(pick_idx_s);
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = owner_q + 2'd1;
          cnt_d   = 4'd0;
        end else if (beat_s) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers; reset clears everything and drops any beat in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = owner_q;
  assign busy      = in_grant_s;
  assign out_valid = valid_s;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (MAX_HOLD = 4) with an expected-value queue.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       busy;

  int vectors;
  int miscompares;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with {gnt, sel, out_valid, busy}.
  task automatic check_now();
    logic [7:0] exp_v;
    logic [7:0] obs_v;
    string      tag;
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    obs_v = {gnt, sel, out_valid, busy};
    vectors++;
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed gnt/sel/ov/busy=%b required %b", tag, obs_v, exp_v);
    end
  endtask

  task automatic expect_out(input logic [3:0] eg, input logic [1:0] es,
                            input logic eov, input logic eb, input string tag);
    exp_q.push_back({eg, es, eov, eb});
    tag_q.push_back(tag);
  endtask

  // One clock cycle: drive inputs just after the edge, check at the falling edge.
  task automatic step(input logic [3:0] r, input logic rdy,
                      input logic [3:0] eg, input logic [1:0] es,
                      input logic eov, input logic eb, input string tag);
    req       = r;
    out_ready = rdy;
    expect_out(eg, es, eov, eb, tag);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] o;
    logic [3:0] oh;
    logic       bp_rdy[7];
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
    bp_rdy    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset values.
    @(posedge clk);
    #1;
    expect_out(4'b0000, 2'd0, 1'b0, 1'b0, "reset_values");
    check_now();
    rst = 1'b0;

    // Single requester 2: grant next cycle, 4 beats, one IDLE, regrant to 2.
    step(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "single_idle0");
    for (int b = 0; b < 4; b++)
      step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, $sformatf("single_beat%0d", b));
    step(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "single_idle1_sel_kept");
    step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, "single_regrant2");
    step(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, "single_drop");
    step(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "single_idle2");

    // Reset mid-grant: ptr is 3, so requester 3 wins first; reset then clears all.
    step(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "rst_pre_idle");
    step(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, "rst_pre_grant3");
    #2;
    rst = 1'b1;
    #1;
    expect_out(4'b0000, 2'd0, 1'b0, 1'b0, "rst_async_clear");
    check_now();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full contention from reset: grants 0,1,2,3,0 each 4 beats plus one IDLE.
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "cont_idle_start");
    for (int g = 0; g < 5; g++) begin
      o  = 2'(g % 4);
      oh = 4'b0001 << o;
      for (int b = 0; b < 4; b++)
        step(4'b1111, 1'b1, oh, o, 1'b1, 1'b1, $sformatf("cont_g%0d_beat%0d", g, b));
      step(4'b1111, 1'b1, 4'b0000, o, 1'b0, 1'b0, $sformatf("cont_g%0d_idle", g));
    end

    // Backpressure on requester 1: 7 granted cycles, release on 4th accepted beat.
    for (int k = 0; k < 7; k++)
      step(4'b0010, bp_rdy[k], 4'b0010, 2'd1, 1'b1, 1'b1, $sformatf("bp_cycle%0d", k));
    step(4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, "bp_idle");

    // Early drop: 3 owns (ptr was 2), drops after 2 beats; 1 wins with ptr 0.
    step(4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, "drop_beat0");
    step(4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, "drop_beat1");
    step(4'b0010, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1, "drop_valid_falls");
    step(4'b0010, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, "drop_idle");
    step(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, "drop_grant1");

    // Late request: 2 rises during 1's grant (ignored), then 0 rises during 2's grant.
    step(4'b0100, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, "late_1_drops");
    step(4'b0100, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, "late_idle_a");
    step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, "late_g2_beat0");
    for (int b = 1; b < 4; b++)
      step(4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, $sformatf("late_g2_beat%0d", b));
    step(4'b0101, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "late_idle_b");
    step(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, "late_grant0_stalled");
    step(4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, "late_0_drops");
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "late_final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
